// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - borrow_in, one WIDTH-bit group per clock LSB first; result after HEIGHT cycles.
// start_in is honoured only while idle; requests during busy are dropped, never queued.
module serial_subtractor #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      start_in,
  input  logic [WIDTH*HEIGHT-1:0]   a_in,
  input  logic [WIDTH*HEIGHT-1:0]   b_in,
  input  logic                      borrow_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [WIDTH*HEIGHT-1:0]   diff_out,
  output logic                      borrow_out,
  output logic                      overflow_out,
  output logic                      zero_out
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int CNT_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HEIGHT - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;

  logic [CNT_W-1:0]   r_cnt;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic [N-1:0]       r_work;
  logic               r_borrow;

  logic               r_done;
  logic [N-1:0]       r_diff;
  logic               r_borrow_out;
  logic               r_overflow;
  logic               r_zero;

  logic [WIDTH-1:0]   w_a_grp;
  logic [WIDTH-1:0]   w_b_grp;
  logic [WIDTH:0]     w_grp;
  logic [N-1:0]       w_diff_full;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_in) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_last = (r_cnt == LAST);
        if (w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Extra top bit of the group difference is the group's borrow-out.
  always_comb begin
    w_a_grp     = r_a[r_cnt*WIDTH +: WIDTH];
    w_b_grp     = r_b[r_cnt*WIDTH +: WIDTH];
    w_grp       = {1'b0, w_a_grp} - {1'b0, w_b_grp} - {{WIDTH{1'b0}}, r_borrow};
    w_diff_full = r_work;
    w_diff_full[r_cnt*WIDTH +: WIDTH] = w_grp[WIDTH-1:0];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_work       <= '0;
      r_borrow     <= 1'b0;
      r_done       <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a      <= a_in;
        r_b      <= b_in;
        r_borrow <= borrow_in;
        r_work   <= '0;
        r_cnt    <= '0;
      end else if (r_state == RUN) begin
        r_work   <= w_diff_full;
        r_borrow <= w_grp[WIDTH];
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_cnt        <= '0;
          r_done       <= 1'b1;
          r_diff       <= w_diff_full;
          r_borrow_out <= w_grp[WIDTH];
          r_overflow   <= (r_a[N-1] != r_b[N-1]) && (w_diff_full[N-1] != r_a[N-1]);
          r_zero       <= (w_diff_full == '0);
        end
      end
    end
  end

  assign busy_out     = (r_state == RUN);
  assign done_out     = r_done;
  assign diff_out     = r_diff;
  assign borrow_out   = r_borrow_out;
  assign overflow_out = r_overflow;
  assign zero_out     = r_zero;

endmodule
